// File: rtl/wb_sram_bridge_if.sv
// Wishbone slave-side bus bundle between the core's master port and the SRAM bridge.
// Signal names follow the bridge's view (_i into the bridge, _o out of it).
interface wb_sram_bridge_if;
    logic [14:0] adr_i;
    logic        we_i;
    logic        cyc_i;
    logic        stb_i;
    logic [1:0]  sel_i;
    logic [15:0] dat_i;
    logic [15:0] dat_o;
    logic        ack_o;

    modport slave (
        input  adr_i,
        input  we_i,
        input  cyc_i,
        input  stb_i,
        input  sel_i,
        input  dat_i,
        output dat_o,
        output ack_o
    );

    modport master (
        output adr_i,
        output we_i,
        output cyc_i,
        output stb_i,
        output sel_i,
        output dat_i,
        input  dat_o,
        input  ack_o
    );
endinterface

// File: rtl/wb_sram_bridge.sv
// Wishbone slave to asynchronous cellular-RAM bridge with programmable read/write wait states.
// Every output is registered; a request is only recognised in idle.
module wb_sram_bridge #(
    parameter int unsigned RD_WAIT = 4,
    parameter int unsigned WR_WAIT = 4,
    parameter int unsigned SRAM_AW = 23
) (
    input  logic               clk_i,
    input  logic               res_i,
    wb_sram_bridge_if.slave    wb,
    output logic [SRAM_AW-1:0] sram_adr_o,
    output logic [15:0]        sram_dq_o,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_i,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);

    typedef enum logic [2:0] {StIdle, StAccess, StHold, StAck, StRecover} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [14:0] adr_q, adr_d;
    logic [15:0] wdat_q, wdat_d;
    logic [15:0] rdat_q, rdat_d;
    logic        ce_n_q, ce_n_d;
    logic        oe_n_q, oe_n_d;
    logic        we_n_q, we_n_d;
    logic        ub_n_q, ub_n_d;
    logic        lb_n_q, lb_n_d;
    logic        dq_oe_q, dq_oe_d;
    logic        ack_q, ack_d;
    logic        req;

    assign req = wb.cyc_i & wb.stb_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        ce_n_d  = ce_n_q;
        oe_n_d  = oe_n_q;
        we_n_d  = we_n_q;
        ub_n_d  = ub_n_q;
        lb_n_d  = lb_n_q;
        dq_oe_d = dq_oe_q;
        ack_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (wb.sel_i != 2'b00) begin
                        adr_d  = wb.adr_i;
                        wdat_d = wb.dat_i;
                        ub_n_d = ~wb.sel_i[1];
                        lb_n_d = ~wb.sel_i[0];
                        wr_d   = wb.we_i;
                        ce_n_d = 1'b0;
                        if (wb.we_i) begin
                            cnt_d   = 4'(WR_WAIT);
                            we_n_d  = 1'b0;
                            dq_oe_d = 1'b1;
                        end else begin
                            cnt_d  = 4'(RD_WAIT);
                            oe_n_d = 1'b0;
                        end
                        state_d = StAccess;
                    end else begin
                        // Null cycle: no byte lanes selected, acknowledge without touching RAM.
                        ack_d   = 1'b1;
                        state_d = StAck;
                    end
                end
            end
            StAccess: begin
                if (!wb.cyc_i) begin
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    state_d = wr_q ? StRecover : StIdle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        if (wr_q) begin
                            // Release we_n first so address/data stay valid past its rising edge.
                            we_n_d  = 1'b1;
                            state_d = StHold;
                        end else begin
                            rdat_d  = sram_dq_i;
                            ce_n_d  = 1'b1;
                            oe_n_d  = 1'b1;
                            ack_d   = 1'b1;
                            state_d = StAck;
                        end
                    end
                end
            end
            StHold: begin
                ce_n_d = 1'b1;
                if (!wb.cyc_i) begin
                    state_d = StRecover;
                end else begin
                    dq_oe_d = 1'b0;
                    ack_d   = 1'b1;
                    state_d = StAck;
                end
            end
            StRecover: begin
                dq_oe_d = 1'b0;
                state_d = StIdle;
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (res_i) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            adr_q   <= 15'd0;
            wdat_q  <= 16'd0;
            rdat_q  <= 16'd0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            ub_n_q  <= 1'b1;
            lb_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            ub_n_q  <= ub_n_d;
            lb_n_q  <= lb_n_d;
            dq_oe_q <= dq_oe_d;
            ack_q   <= ack_d;
        end
    end

    assign wb.dat_o   = rdat_q;
    assign wb.ack_o   = ack_q;
    assign sram_adr_o = SRAM_AW'(adr_q);
    assign sram_dq_o  = wdat_q;
    assign sram_dq_oe = dq_oe_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;
    assign sram_ub_n  = ub_n_q;
    assign sram_lb_n  = lb_n_q;

endmodule

// File: tb/tb_wb_sram_bridge.sv
// Bench for wb_sram_bridge: per-cycle expected pin schedule built from the access latencies,
// an asynchronous RAM pad model, and directed transactions with literal expectations.
module tb_wb_sram_bridge;

    localparam int RD_WAIT = 4;
    localparam int WR_WAIT = 4;
    localparam int NCYC    = 1024;

    // Expected strobe vector {ack, ce_n, oe_n, we_n, dq_oe}
    localparam logic [4:0] S_IDLE = 5'b01110;
    localparam logic [4:0] S_RD   = 5'b00010;
    localparam logic [4:0] S_WR   = 5'b00101;
    localparam logic [4:0] S_HOLD = 5'b00111;
    localparam logic [4:0] S_ACK  = 5'b11110;

    logic        clk = 1'b0;
    logic        res;
    logic [22:0] sram_adr;
    logic [15:0] sram_dq_o;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_i;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    wb_sram_bridge_if wb ();

    wb_sram_bridge #(
        .RD_WAIT (RD_WAIT),
        .WR_WAIT (WR_WAIT),
        .SRAM_AW (23)
    ) dut (
        .clk_i      (clk),
        .res_i      (res),
        .wb         (wb),
        .sram_adr_o (sram_adr),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_i  (sram_dq_i),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n),
        .sram_ub_n  (sram_ub_n),
        .sram_lb_n  (sram_lb_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Asynchronous RAM pad model
    logic [15:0] sram_mem [0:1023];
    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_adr[9:0]] : 16'h0000;
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
            if (!sram_ub_n) sram_mem[sram_adr[9:0]][15:8] <= sram_dq_o[15:8];
            if (!sram_lb_n) sram_mem[sram_adr[9:0]][7:0]  <= sram_dq_o[7:0];
        end
    end

    // Expected per-cycle schedule, indexed by number of rising edges seen
    logic [4:0]  e_stb [0:NCYC-1];
    logic [1:0]  e_bl  [0:NCYC-1];
    logic [14:0] e_adr [0:NCYC-1];
    logic [15:0] e_dat [0:NCYC-1];
    logic [15:0] e_dqo [0:NCYC-1];
    logic [15:0] model_mem [0:1023];

    int n_cmp = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic idle_from(input int t);
        for (int n = t; n < NCYC; n++) e_stb[n] = S_IDLE;
    endtask

    task automatic set_stb(input int n, input logic [4:0] v);
        if (n < NCYC) e_stb[n] = v;
    endtask

    task automatic latch_from(input int t, input logic [14:0] a, input logic [1:0] bl,
                              input logic [15:0] d);
        for (int n = t; n < NCYC; n++) begin
            e_adr[n] = a;
            e_bl[n]  = bl;
            e_dqo[n] = d;
        end
    endtask

    task automatic dat_from(input int t, input logic [15:0] d);
        for (int n = t; n < NCYC; n++) e_dat[n] = d;
    endtask

    // cut > 0: the master drops cyc_i so that only 'cut' access cycles happen
    task automatic plan_read(input int t0, input logic [14:0] a, input logic [1:0] sel,
                             input logic [15:0] d, input int cut);
        int steps;
        steps = (cut > 0) ? cut : RD_WAIT;
        latch_from(t0, a, ~sel, d);
        idle_from(t0);
        for (int k = 0; k < steps; k++) set_stb(t0 + k, S_RD);
        if (cut == 0) begin
            set_stb(t0 + RD_WAIT, S_ACK);
            dat_from(t0 + RD_WAIT, model_mem[a[9:0]]);
        end
    endtask

    task automatic plan_write(input int t0, input logic [14:0] a, input logic [1:0] sel,
                              input logic [15:0] d);
        latch_from(t0, a, ~sel, d);
        idle_from(t0);
        for (int k = 0; k < WR_WAIT; k++) set_stb(t0 + k, S_WR);
        set_stb(t0 + WR_WAIT, S_HOLD);
        set_stb(t0 + WR_WAIT + 1, S_ACK);
        if (sel[1]) model_mem[a[9:0]][15:8] = d[15:8];
        if (sel[0]) model_mem[a[9:0]][7:0]  = d[7:0];
    endtask

    task automatic plan_reset(input int t);
        idle_from(t);
        latch_from(t, 15'd0, 2'b11, 16'd0);
        dat_from(t, 16'd0);
    endtask

    // Per-cycle comparison against the schedule
    always @(negedge clk) begin
        if (check_en && cyc < NCYC) begin
            chk("strobes", 32'({wb.ack_o, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}),
                32'(e_stb[cyc]));
            chk("byte_en", 32'({sram_ub_n, sram_lb_n}), 32'(e_bl[cyc]));
            chk("sram_adr", 32'(sram_adr), 32'(e_adr[cyc]));
            chk("dat_o", 32'(wb.dat_o), 32'(e_dat[cyc]));
            if (e_stb[cyc][0]) chk("sram_dq_o", 32'(sram_dq_o), 32'(e_dqo[cyc]));
        end
    end

    task automatic do_req(input bit we, input logic [14:0] a, input logic [1:0] sel,
                          input logic [15:0] d, input bit hold, output int lat,
                          output int lo_cnt, output int ce_cnt, output int ack_at,
                          output logic [1:0] bl_first);
        int t0;
        t0 = cyc + 1;
        if (sel == 2'b00) begin
            idle_from(t0);
            set_stb(t0, S_ACK);
        end else if (we) begin
            plan_write(t0, a, sel, d);
        end else begin
            plan_read(t0, a, sel, d, 0);
        end
        wb.adr_i = a;
        wb.we_i  = we;
        wb.sel_i = sel;
        wb.dat_i = d;
        wb.cyc_i = 1'b1;
        wb.stb_i = 1'b1;
        lat      = -1;
        lo_cnt   = 0;
        ce_cnt   = 0;
        ack_at   = -1;
        bl_first = 2'bxx;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (i == 0) bl_first = {sram_ub_n, sram_lb_n};
            if (!sram_oe_n || !sram_we_n) lo_cnt++;
            if (!sram_ce_n) ce_cnt++;
            if (wb.ack_o) begin
                lat    = cyc + 1 - t0;
                ack_at = cyc;
                break;
            end
        end
        chk("ack_seen", 32'(lat >= 0), 32'd1);
        if (!hold) begin
            wb.cyc_i = 1'b0;
            wb.stb_i = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic count_acks(input int n, output int acks);
        acks = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (wb.ack_o) acks++;
        end
    endtask

    initial begin
        int lat, lo, ce, at1, at2, at3, acks, t0;
        logic [1:0] bl;

        for (int n = 0; n < NCYC; n++) begin
            e_stb[n] = S_IDLE;
            e_bl[n]  = 2'b11;
            e_adr[n] = 15'd0;
            e_dat[n] = 16'd0;
            e_dqo[n] = 16'd0;
        end
        for (int i = 0; i < 1024; i++) begin
            sram_mem[i]  = 16'h0000;
            model_mem[i] = 16'h0000;
        end
        sram_mem[10'h040] = 16'h5500;  model_mem[10'h040] = 16'h5500;
        sram_mem[10'h001] = 16'h1111;  model_mem[10'h001] = 16'h1111;
        sram_mem[10'h002] = 16'h2222;  model_mem[10'h002] = 16'h2222;
        sram_mem[10'h003] = 16'h3333;  model_mem[10'h003] = 16'h3333;

        res      = 1'b1;
        wb.adr_i = '0;
        wb.we_i  = 1'b0;
        wb.cyc_i = 1'b0;
        wb.stb_i = 1'b0;
        wb.sel_i = 2'b00;
        wb.dat_i = '0;

        @(negedge clk);
        check_en = 1'b1;
        @(negedge clk);
        chk("reset_ack", 32'(wb.ack_o), 32'd0);
        chk("reset_ce_n", 32'(sram_ce_n), 32'd1);
        chk("reset_dq_oe", 32'(sram_dq_oe), 32'd0);
        chk("reset_dat_o", 32'(wb.dat_o), 32'd0);
        res = 1'b0;
        @(negedge clk);

        // Full-word write then read back
        do_req(1'b1, 15'h0123, 2'b11, 16'hBEEF, 1'b0, lat, lo, ce, at1, bl);
        chk("wr_latency", 32'(lat), 32'd6);
        chk("wr_we_low_cycles", 32'(lo), 32'd4);
        chk("wr_ce_low_cycles", 32'(ce), 32'd5);
        do_req(1'b0, 15'h0123, 2'b11, 16'h0000, 1'b0, lat, lo, ce, at1, bl);
        chk("rd_latency", 32'(lat), 32'd5);
        chk("rd_oe_low_cycles", 32'(lo), 32'd4);
        chk("rd_data", 32'(wb.dat_o), 32'h0000BEEF);

        // Lower byte lane write, full word read merges with prefilled upper byte
        do_req(1'b1, 15'h0040, 2'b01, 16'h00AA, 1'b0, lat, lo, ce, at1, bl);
        chk("byte_lanes", 32'(bl), 32'b10);
        do_req(1'b0, 15'h0040, 2'b11, 16'h0000, 1'b0, lat, lo, ce, at1, bl);
        chk("byte_rd_data", 32'(wb.dat_o), 32'h000055AA);

        // Null cycle
        do_req(1'b0, 15'h0055, 2'b00, 16'h0000, 1'b0, lat, lo, ce, at1, bl);
        chk("null_latency", 32'(lat), 32'd1);
        chk("null_ce_low_cycles", 32'(ce), 32'd0);
        chk("null_dat_kept", 32'(wb.dat_o), 32'h000055AA);

        // Back-to-back reads with stb held
        do_req(1'b0, 15'h0001, 2'b11, 16'h0000, 1'b1, lat, lo, ce, at1, bl);
        chk("b2b_data1", 32'(wb.dat_o), 32'h00001111);
        do_req(1'b0, 15'h0002, 2'b11, 16'h0000, 1'b1, lat, lo, ce, at2, bl);
        chk("b2b_data2", 32'(wb.dat_o), 32'h00002222);
        do_req(1'b0, 15'h0003, 2'b11, 16'h0000, 1'b0, lat, lo, ce, at3, bl);
        chk("b2b_data3", 32'(wb.dat_o), 32'h00003333);
        chk("b2b_gap12", 32'(at2 - at1), 32'd6);
        chk("b2b_gap23", 32'(at3 - at2), 32'd6);

        // Abort a read in its second access cycle
        t0 = cyc + 1;
        plan_read(t0, 15'h0123, 2'b11, 16'h0000, 2);
        wb.adr_i = 15'h0123;
        wb.we_i  = 1'b0;
        wb.sel_i = 2'b11;
        wb.cyc_i = 1'b1;
        wb.stb_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        wb.cyc_i = 1'b0;
        wb.stb_i = 1'b0;
        @(negedge clk);
        chk("abort_oe_ce", 32'({sram_oe_n, sram_ce_n}), 32'b11);
        count_acks(8, acks);
        chk("abort_no_ack", 32'(acks), 32'd0);
        chk("abort_dat_kept", 32'(wb.dat_o), 32'h00003333);
        do_req(1'b0, 15'h0123, 2'b11, 16'h0000, 1'b0, lat, lo, ce, at1, bl);
        chk("after_abort_latency", 32'(lat), 32'd5);
        chk("after_abort_data", 32'(wb.dat_o), 32'h0000BEEF);

        // Reset in the second access cycle of a write
        t0 = cyc + 1;
        plan_write(t0, 15'h0010, 2'b11, 16'h1234);
        wb.adr_i = 15'h0010;
        wb.we_i  = 1'b1;
        wb.sel_i = 2'b11;
        wb.dat_i = 16'h1234;
        wb.cyc_i = 1'b1;
        wb.stb_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        res      = 1'b1;
        wb.cyc_i = 1'b0;
        wb.stb_i = 1'b0;
        plan_reset(cyc + 1);
        @(negedge clk);
        chk("rst_strobes", 32'({sram_we_n, sram_ce_n, sram_dq_oe, wb.ack_o}), 32'b1100);
        res = 1'b0;
        count_acks(10, acks);
        chk("rst_no_ack", 32'(acks), 32'd0);
        do_req(1'b0, 15'h0002, 2'b11, 16'h0000, 1'b0, lat, lo, ce, at1, bl);
        chk("after_rst_data", 32'(wb.dat_o), 32'h00002222);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no end, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wb_sram_bridge.md
Name: wb_sram_bridge

Overview:
- Wishbone slave that sits directly downstream of the STEAMER16X4 core's bus master port on the Nexys2 board.
- Converts each 16-bit Wishbone cycle into an asynchronous-mode cellular-RAM access with programmable wait states, then returns a single-cycle ack.
- Read data is registered and presented together with ack.
- Replaces the zero-wait-state assumption on the core's bus so that slow external RAM can be used.

Parameters:
- RD_WAIT, 4: cycles that oe_n/ce_n stay asserted before read data is sampled; legal range 1..15.
- WR_WAIT, 4: cycles that we_n stays asserted during a write; legal range 1..15.
- SRAM_AW, 23: width of the external word address bus.

Ports:
- clk_i  in  1  system clock; all state changes on its rising edge.
- res_i  in  1  synchronous, active-high reset.
- adr_i  in  15  Wishbone word address, bits [15:1].
- we_i  in  1  1 = write cycle.
- cyc_i  in  1  bus cycle in progress.
- stb_i  in  1  strobe; a request is cyc_i & stb_i.
- sel_i  in  2  byte lanes; [1] = upper byte, [0] = lower byte.
- dat_i  in  16  write data.
- dat_o  out  16  registered read data.
- ack_o  out  1  registered one-cycle acknowledge.
- sram_adr_o  out  SRAM_AW  external address = {zeros, latched adr[15:1]}.
- sram_dq_o  out  16  data driven to the pad tristate.
- sram_dq_oe  out  1  1 = FPGA drives the DQ pads.
- sram_dq_i  in  16  data from the DQ pads.
- sram_ce_n  out  1  chip enable, active low.
- sram_oe_n  out  1  output enable, active low.
- sram_we_n  out  1  write enable, active low.
- sram_ub_n  out  1  upper-byte enable, active low.
- sram_lb_n  out  1  lower-byte enable, active low.

Behaviour:
- Reset values (next edge with res_i=1, from any state): state IDLE; ack_o=0; dat_o=0; sram_ce_n=sram_oe_n=sram_we_n=sram_ub_n=sram_lb_n=1; sram_dq_oe=0; sram_adr_o=0; wait counter=0.
- All outputs are registered; no combinational path from Wishbone inputs to SRAM pins or to ack_o.
- IDLE, request seen and sel_i!=00:
  - Latch adr_i, dat_i, ~sel_i (onto ub_n/lb_n) and we_i.
  - Load counter with RD_WAIT or WR_WAIT.
  - Go to ACCESS.
- IDLE, request seen and sel_i==00: null cycle. Go to ACK with no SRAM strobes asserted; dat_o is unchanged.
- ACCESS:
  - sram_ce_n=0.
  - Read: sram_oe_n=0, sram_dq_oe=0.
  - Write: sram_we_n=0, sram_dq_oe=1, sram_dq_o = latched data.
  - Counter decrements each cycle.
  - When counter==1:
    - Read: dat_o <= sram_dq_i; deassert ce_n/oe_n; go to ACK.
    - Write: deassert we_n only, keeping ce_n, address, data and dq_oe; go to HOLD.
- HOLD (writes only): one cycle with we_n=1 and ce_n=0, address and data held. Then deassert ce_n and dq_oe, go to ACK.
- ACK: ack_o=1 for exactly one cycle, all strobes deasserted; next state IDLE.
  - The master still holds stb_i during ACK; this is not treated as a new request.
  - A new request is recognised only in IDLE, so back-to-back requests are honoured starting the cycle after ACK.
- Latency from the request-sampling edge to the edge where ack is sampled:
  - read = RD_WAIT + 1
  - write = WR_WAIT + 2
  - null = 1
- Upper-byte writes: sram_dq_o carries the full dat_i word. The master places byte data on the correct lane; the bridge does not swizzle.
- Abort: if cyc_i=0 while in ACCESS or HOLD:
  - Deassert oe_n/we_n that edge.
  - For a write, keep address/data for one RECOVER cycle with ce_n=1.
  - Then go to IDLE with no ack; dat_o is unchanged.
- Reset mid-access: strobes deassert on the reset edge, no ack is issued, and the access is lost. A partial write to RAM is acceptable.
- Counter is 4 bits; values 0 and >15 are illegal parameter values and are not checked at runtime.

Test Plan:
- Reset during a write: assert res_i in the 2nd ACCESS cycle of a write to 0x0010 → next edge we_n=1, ce_n=1, dq_oe=0, ack_o=0; after release, state IDLE and no ack is ever generated.
- Write then read, RD_WAIT=WR_WAIT=4: write 0xBEEF to adr 0x0123 with sel=11 → we_n low for exactly 4 cycles, one HOLD cycle, ack on cycle 6. Read adr 0x0123 → oe_n low for 4 cycles, ack on cycle 5, dat_o=0xBEEF.
- Byte lanes: write 0x00AA with sel=01 to adr 0x0040 → lb_n=0, ub_n=1. A subsequent sel=11 read of a model pre-filled with 0x5500 returns 0x55AA.
- Null cycle: request with sel=00 → ack_o on the next edge, ce_n never asserted, dat_o unchanged.
- Back-to-back reads of 0x0001, 0x0002, 0x0003 with stb held continuously → exactly three acks, each separated by RD_WAIT+2 cycles, with matching data.
- Abort: drop cyc_i in the 2nd ACCESS cycle of a read → oe_n/ce_n high on the next edge, no ack, return to IDLE; a following read completes normally.
